// File: rtl/cluster_priority_seq.sv
// Sequential priority encoder: latches one frame of pad flags and counts, then
// reports up to MXCLUSTERS hits, one per clock, in ascending key order.
module cluster_priority_seq #(
  parameter int MXKEYS     = 384,
  parameter int MXKEYBITS  = 9,
  parameter int MXCNTB     = 3,
  parameter int MXCLUSTERS = 8,
  localparam int IDXW      = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_i,
  input  logic [MXKEYS-1:0]        vpfs_i,
  input  logic [MXKEYS*MXCNTB-1:0] cnts_i,
  input  logic [2:0]               pass_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [MXKEYBITS-1:0]     adr_o,
  output logic [MXCNTB-1:0]        cnt_o,
  output logic [IDXW-1:0]          idx_o,
  output logic [2:0]               pass_o,
  output logic                     last_o,
  output logic                     done_o,
  output logic                     overflow_o
);

  localparam int LVLS  = $clog2(MXKEYS);
  localparam int PADW  = 1 << LVLS;
  localparam int NODES = 2 * PADW - 1;

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t                     state_q, state_d;
  logic [MXKEYS-1:0]          mask_q, mask_d;
  logic [MXKEYS*MXCNTB-1:0]   cnt_q;
  logic [IDXW-1:0]            hit_q, hit_d;
  logic                       load_cnts;

  logic                       busy_d, valid_d, last_d, done_d, ovf_d;
  logic [MXKEYBITS-1:0]       adr_d;
  logic [MXCNTB-1:0]          cnt_d;
  logic [IDXW-1:0]            idx_d;
  logic [2:0]                 pass_d;

  // Heap-ordered tree: node n has children 2n+1 (lower keys) and 2n+2.
  logic [NODES-1:0]           tree_v;
  logic [MXKEYBITS-1:0]       tree_a [NODES];

  genvar gi;
  generate
    for (gi = 0; gi < PADW; gi++) begin : g_leaf
      if (gi < MXKEYS) begin : g_real
        assign tree_v[PADW-1+gi] = mask_q[gi];
      end else begin : g_pad
        assign tree_v[PADW-1+gi] = 1'b0;
      end
      assign tree_a[PADW-1+gi] = MXKEYBITS'(gi);
    end
    for (gi = 0; gi < PADW - 1; gi++) begin : g_node
      assign tree_v[gi] = tree_v[2*gi+1] | tree_v[2*gi+2];
      assign tree_a[gi] = tree_v[2*gi+1] ? tree_a[2*gi+1] : tree_a[2*gi+2];
    end
  endgenerate

  logic                 found;
  logic [MXKEYBITS-1:0] win_adr;
  logic [MXCNTB-1:0]    win_cnt;
  logic [MXKEYS-1:0]    rem_mask;

  assign found   = tree_v[0];
  assign win_adr = tree_a[0];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    win_cnt  = '0;
    rem_mask = mask_q;
    for (int k = 0; k < MXKEYS; k++) begin
      if (win_adr == MXKEYBITS'(k)) begin
        win_cnt     = cnt_q[k*MXCNTB +: MXCNTB];
        rem_mask[k] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    hit_d     = hit_q;
    load_cnts = 1'b0;
    valid_d   = 1'b0;
    adr_d     = '1;
    cnt_d     = '0;
    idx_d     = idx_o;
    pass_d    = pass_o;
    last_d    = 1'b0;
    done_d    = 1'b0;
    ovf_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          mask_d    = vpfs_i;
          hit_d     = '0;
          pass_d    = pass_i;
          load_cnts = 1'b1;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        if (found) begin
          valid_d = 1'b1;
          adr_d   = win_adr;
          cnt_d   = win_cnt;
          idx_d   = hit_q;
          hit_d   = hit_q + IDXW'(1);
          mask_d  = rem_mask;
        end
        // An empty mask leaves rem_mask empty too, so it ends here as well.
        if (rem_mask == '0 || hit_q == IDXW'(MXCLUSTERS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          last_d  = found;
          ovf_d   = |rem_mask;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SEARCH);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      hit_q      <= '0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      adr_o      <= '1;
      cnt_o      <= '0;
      idx_o      <= '0;
      pass_o     <= 3'd0;
      last_o     <= 1'b0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      hit_q      <= hit_d;
      busy_o     <= busy_d;
      valid_o    <= valid_d;
      adr_o      <= adr_d;
      cnt_o      <= cnt_d;
      idx_o      <= idx_d;
      pass_o     <= pass_d;
      last_o     <= last_d;
      done_o     <= done_d;
      overflow_o <= ovf_d;
    end
  end

  // NOTE: the count store is plain data read only under a set mask bit, so it carries no reset.
  always_ff @(posedge clock) begin
    if (load_cnts) begin
      cnt_q <= cnts_i;
    end
  end

endmodule
